// File: rtl/mem_stream_loader.sv
// Byte-stream loader: packs bytes little-endian into 32-bit words, writes them to memory,
// reads them back and compares an additive checksum. Holds the core in reset meanwhile.
module mem_stream_loader #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              mem_read_cmd_valid,
  output logic              mem_write_cmd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_write_data_valid,
  output logic [3:0]        mem_write_data_size,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_read_data_valid,
  output logic              busy,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam int unsigned TmrW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StRdReq,
    StRdWait,
    StDone
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  idx_q;
  logic [1:0]        lane_q;
  logic [31:0]       word_q;
  logic [31:0]       rb_sum_q;
  logic [TmrW-1:0]   tmr_q;
  logic              in_ready_q;
  logic              rd_cmd_q;
  logic              wr_cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wsize_q;
  logic              busy_q;
  logic              hold_q;
  logic              done_q;
  logic              error_q;
  logic [31:0]       checksum_q;

  logic [CNT_W-1:0]  idx_inc;
  logic [ADDR_W-1:0] addr_cur;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       rb_sum_nx;
  logic              tmr_expire;

  always_comb begin
    idx_inc    = idx_q + 1'b1;
    addr_cur   = base_q + ADDR_W'({idx_q, 2'b00});
    addr_nxt   = base_q + ADDR_W'({idx_inc, 2'b00});
    rb_sum_nx  = rb_sum_q + mem_read_data;
    // Expiring at RD_TIMEOUT-2 makes DONE/error appear RD_TIMEOUT cycles after the read strobe.
    tmr_expire = (tmr_q == TmrW'(RD_TIMEOUT - 2));
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      rb_sum_q   <= '0;
      tmr_q      <= '0;
      in_ready_q <= 1'b0;
      rd_cmd_q   <= 1'b0;
      wr_cmd_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wsize_q    <= '0;
      busy_q     <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      checksum_q <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            base_q     <= base_addr & ~ADDR_W'(3);
            cnt_q      <= word_count;
            idx_q      <= '0;
            lane_q     <= '0;
            rb_sum_q   <= '0;
            checksum_q <= '0;
            error_q    <= 1'b0;
            if (word_count == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q    <= StCollect;
              done_q     <= 1'b0;
              hold_q     <= 1'b1;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
            end
          end
        end
        StCollect: begin
          if (in_valid) begin
            word_q[8*lane_q +: 8] <= in_data;
            lane_q                <= lane_q + 1'b1;
            if (lane_q == 2'd3) begin
              state_q    <= StWrite;
              in_ready_q <= 1'b0;
              wr_cmd_q   <= 1'b1;
              wsize_q    <= 4'hF;
              addr_q     <= addr_cur;
              wdata_q    <= {in_data, word_q[23:0]};
            end
          end
        end
        StWrite: begin
          wr_cmd_q   <= 1'b0;
          checksum_q <= checksum_q + wdata_q;
          if (idx_inc == cnt_q) begin
            idx_q    <= '0;
            state_q  <= StRdReq;
            rd_cmd_q <= 1'b1;
            addr_q   <= base_q;
          end else begin
            idx_q      <= idx_inc;
            state_q    <= StCollect;
            in_ready_q <= 1'b1;
          end
        end
        StRdReq: begin
          rd_cmd_q <= 1'b0;
          tmr_q    <= '0;
          state_q  <= StRdWait;
        end
        StRdWait: begin
          if (mem_read_data_valid) begin
            rb_sum_q <= rb_sum_nx;
            idx_q    <= idx_inc;
            if (idx_inc == cnt_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              hold_q  <= 1'b0;
              error_q <= (rb_sum_nx != checksum_q);
            end else begin
              state_q  <= StRdReq;
              rd_cmd_q <= 1'b1;
              addr_q   <= addr_nxt;
            end
          end else if (tmr_expire) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            hold_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready             = in_ready_q;
  assign mem_read_cmd_valid   = rd_cmd_q;
  assign mem_write_cmd_valid  = wr_cmd_q;
  assign mem_write_data_valid = wr_cmd_q;
  assign mem_addr             = addr_q;
  assign mem_write_data       = wdata_q;
  assign mem_write_data_size  = wsize_q;
  assign busy                 = busy_q;
  assign core_hold            = hold_q;
  assign done                 = done_q;
  assign error                = error_q;
  assign checksum             = checksum_q;

endmodule

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Initiator on the mem_32 command interface, the counterpart to the memory responder. Drives the same signal set the core drives.
- Accepts a byte stream (valid/ready) and packs it little-endian into 32-bit words. Writes the words to consecutive addresses, then reads every word back and checks an additive checksum.
- Holds the core in reset while loading. Sits beside the core in the top level and is muxed onto the instruction- or data-memory port while busy.

Parameters:
- ADDR_W, 32, width of the memory byte address.
- CNT_W, 16, width of the word-count input.
- RD_TIMEOUT, 64, cycles to wait for read_data_valid before flagging an error.

Ports:
- sys_clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; ignored unless idle.
- base_addr  in  ADDR_W  byte address of the first word; bits [1:0] are ignored (treated as 0).
- word_count  in  CNT_W  number of words to load; 0 is legal.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  stream byte accepted when in_valid && in_ready.
- in_data  in  8  stream byte.
- mem_read_cmd_valid  out  1  read command strobe.
- mem_write_cmd_valid  out  1  write command strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_write_data  out  32  write word.
- mem_write_data_valid  out  1  write data strobe.
- mem_write_data_size  out  4  byte-enable mask.
- mem_read_data  in  32  read word.
- mem_read_data_valid  in  1  read response strobe.
- busy  out  1  high in any state other than IDLE or DONE.
- core_hold  out  1  high from start until DONE; external logic ORs it into the core reset.
- done  out  1  level, high in DONE.
- error  out  1  valid while done; set on checksum mismatch or read timeout.
- checksum  out  32  sum of all written words, modulo 2^32.

Behaviour:
- Reset values: all outputs 0. State IDLE. Internal counters, byte lane index and checksum cleared. Reset in any state aborts the operation and produces no further memory strobes.
- States: IDLE, COLLECT, WRITE, RD_REQ, RD_WAIT, DONE.
- IDLE:
  - On start, latch base_addr (low 2 bits forced to 0) and word_count. Clear checksum, the readback sum and error. Assert core_hold.
  - word_count == 0: go to DONE next cycle with error = 0 and checksum = 0.
  - Otherwise go to COLLECT.
- COLLECT:
  - in_ready = 1. Each accepted byte fills lane k (bits 8k+7:8k), k = 0..3.
  - On the 4th byte, go to WRITE.
  - in_ready is 0 in every other state.
- WRITE (exactly 1 cycle):
  - mem_write_cmd_valid = mem_write_data_valid = 1, mem_write_data_size = 4'hF.
  - mem_addr = base + 4*i, where i is the word index.
  - checksum += word; i++.
  - If i reaches word_count, reset i to 0 and go to RD_REQ; otherwise go to COLLECT.
- RD_REQ (1 cycle):
  - mem_read_cmd_valid = 1, mem_addr = base + 4*i.
  - Go to RD_WAIT and clear the timeout counter.
- RD_WAIT:
  - On mem_read_data_valid, add mem_read_data to the readback sum and increment i.
  - If more words remain, go to RD_REQ. Otherwise go to DONE with error = (readback sum != checksum).
  - If mem_read_data_valid arrives in the same cycle the timeout expires, the data wins.
  - On timeout (RD_TIMEOUT cycles without valid), go to DONE with error = 1.
- Strobes: all mem_* strobes are single-cycle. Read and write are never asserted together. mem_addr, mem_write_data and size hold their last value when no strobe is asserted.
- DONE:
  - done = 1, core_hold = 0. checksum and error stay stable.
  - start re-arms: go through IDLE handling in the same cycle, so done drops the next cycle.
- Address arithmetic wraps modulo 2^ADDR_W. A mem_read_data_valid arriving outside RD_WAIT is ignored.
- start while busy is ignored.

Test Plan:
- base=0x100, count=2, stream 11 22 33 44 55 66 77 88 → writes 0x44332211 @0x100 and 0x88776655 @0x104, both with size F. Then reads @0x100 and @0x104; done=1, error=0, checksum=0xCCAA8866.
- count=0, start → done in 2 cycles, no mem strobes, error=0, checksum=0.
- Stream with random in_valid gaps, count=3 → identical writes; in_ready low outside COLLECT; core_hold high until done.
- Responder corrupts the 2nd readback by +1 → error=1, done=1.
- Responder never returns read_data_valid → error=1 exactly RD_TIMEOUT cycles after the read strobe.
- Reset asserted mid-WRITE sequence (after 1 of 3 words) → all outputs 0 next cycle, no further strobes. A subsequent start loads correctly.
